// File: rtl/alu_writeback.sv
// alu_writeback: commit stage behind alu_core in the 8051 datapath.
//
// Takes ALU results and flags and commits them to ACC, B, PSW or internal RAM.
// It owns the architectural ACC/B/PSW registers and returns CY/AC to the ALU.
// Direct SFR writes are merged in every cycle. A RAM write is held until the
// RAM acknowledges it.
//
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   wb_valid/wb_ready   - result handshake (no buffering while not ready)
//   wb_dest             - 00 flags only, 01 ACC, 10 ACC+B, 11 RAM
//   wb_flag_mask        - [2] CY, [1] AC, [0] OV update enables
//   wb_addr             - RAM destination address
//   op_out_1/op_out_2   - ALU primary / secondary result
//   carry_out, aux_carry_out, overflow_out - ALU flags
//   sfr_wr/sfr_addr/sfr_data - direct SFR write port
//   ram_wr_en/ram_wr_addr/ram_wr_data/ram_ack - held RAM write request
//   acc, b_reg, psw     - architectural registers
//   carry_in, aux_carry_in - psw[7], psw[6] fed back to alu_core
module alu_writeback #(
  parameter int          ADDR_W  = 8,
  parameter logic [7:0]  SFR_ACC = 8'hE0,
  parameter logic [7:0]  SFR_B   = 8'hF0,
  parameter logic [7:0]  SFR_PSW = 8'hD0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [1:0]        wb_dest,
  input  logic [2:0]        wb_flag_mask,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [7:0]        op_out_1,
  input  logic [7:0]        op_out_2,
  input  logic              carry_out,
  input  logic              aux_carry_out,
  input  logic              overflow_out,
  input  logic              sfr_wr,
  input  logic [7:0]        sfr_addr,
  input  logic [7:0]        sfr_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data,
  input  logic              ram_ack,
  output logic [7:0]        acc,
  output logic [7:0]        b_reg,
  output logic [7:0]        psw,
  output logic              carry_in,
  output logic              aux_carry_in
);

  typedef enum logic {IDLE = 1'b0, RAM_WAIT = 1'b1} state_t;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_ACC  = 2'b01;
  localparam logic [1:0] DEST_AB   = 2'b10;
  localparam logic [1:0] DEST_RAM  = 2'b11;

  state_t            state_q, state_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        b_q, b_d;
  logic [7:0]        psw_q, psw_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              accept;

  assign wb_ready = (state_q == IDLE);
  assign accept   = wb_valid && wb_ready;

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && wb_dest == DEST_RAM) state_d = RAM_WAIT;
      RAM_WAIT: if (ram_ack && ram_en_q)           state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Register updates. The SFR value is applied first so that the ALU value
  // overrides it on a same-register collision.
  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    psw_d = psw_q;

    if (sfr_wr) begin
      if (sfr_addr == SFR_ACC) acc_d = sfr_data;
      if (sfr_addr == SFR_B)   b_d   = sfr_data;
      if (sfr_addr == SFR_PSW) psw_d = sfr_data;
    end

    if (accept) begin
      if (wb_dest == DEST_ACC || wb_dest == DEST_AB) acc_d = op_out_1;
      if (wb_dest == DEST_AB)                        b_d   = op_out_2;
      if (wb_flag_mask[2]) psw_d[7] = carry_out;
      if (wb_flag_mask[1]) psw_d[6] = aux_carry_out;
      if (wb_flag_mask[0]) psw_d[2] = overflow_out;
    end

    // P is never written directly; it always tracks the next ACC value.
    psw_d[0] = ^acc_d;
  end

  // RAM request: captured at accept, held until acknowledged.
  always_comb begin
    ram_en_d   = ram_en_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    if (accept && wb_dest == DEST_RAM) begin
      ram_en_d   = 1'b1;
      ram_addr_d = wb_addr;
      ram_data_d = op_out_1;
    end else if (ram_en_q && ram_ack) begin
      ram_en_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= 8'h00;
      b_q        <= 8'h00;
      psw_q      <= 8'h00;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      psw_q      <= psw_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign acc          = acc_q;
  assign b_reg        = b_q;
  assign psw          = psw_q;
  assign ram_wr_en    = ram_en_q;
  assign ram_wr_addr  = ram_addr_q;
  assign ram_wr_data  = ram_data_q;
  assign carry_in     = psw_q[7];
  assign aux_carry_in = psw_q[6];

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback with hand-computed expected values.
module tb_alu_writeback;
  logic       clock = 1'b0;
  logic       reset;
  logic       wb_valid, wb_ready;
  logic [1:0] wb_dest;
  logic [2:0] wb_flag_mask;
  logic [7:0] wb_addr, op_out_1, op_out_2;
  logic       carry_out, aux_carry_out, overflow_out;
  logic       sfr_wr;
  logic [7:0] sfr_addr, sfr_data;
  logic       ram_wr_en, ram_ack;
  logic [7:0] ram_wr_addr, ram_wr_data;
  logic [7:0] acc, b_reg, psw;
  logic       carry_in, aux_carry_in;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_writeback dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
    .wb_flag_mask(wb_flag_mask), .wb_addr(wb_addr),
    .op_out_1(op_out_1), .op_out_2(op_out_2),
    .carry_out(carry_out), .aux_carry_out(aux_carry_out), .overflow_out(overflow_out),
    .sfr_wr(sfr_wr), .sfr_addr(sfr_addr), .sfr_data(sfr_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_ack(ram_ack),
    .acc(acc), .b_reg(b_reg), .psw(psw),
    .carry_in(carry_in), .aux_carry_in(aux_carry_in)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic alu(input logic [1:0] dest, input logic [2:0] mask,
                     input logic [7:0] o1, input logic [7:0] o2,
                     input logic cy, input logic ac, input logic ov);
    wb_valid = 1'b1; wb_dest = dest; wb_flag_mask = mask;
    op_out_1 = o1; op_out_2 = o2;
    carry_out = cy; aux_carry_out = ac; overflow_out = ov;
  endtask

  task automatic idle_in();
    wb_valid = 1'b0; sfr_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_dest = 2'b00; wb_flag_mask = 3'b000;
    wb_addr = 8'h00; op_out_1 = 8'h00; op_out_2 = 8'h00;
    carry_out = 1'b0; aux_carry_out = 1'b0; overflow_out = 1'b0;
    sfr_wr = 1'b0; sfr_addr = 8'h00; sfr_data = 8'h00; ram_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_acc", acc, 8'h00);
    chk("rst_b", b_reg, 8'h00);
    chk("rst_psw", psw, 8'h00);
    chk("rst_ram_en", ram_wr_en, 1'b0);
    chk("rst_ready", wb_ready, 1'b1);

    // 1: ADD to ACC
    alu(2'b01, 3'b111, 8'h60, 8'h00, 1'b0, 1'b0, 1'b0);
    step(); idle_in();
    chk("add_acc", acc, 8'h60);
    chk("add_psw", psw, 8'h00);
    chk("add_cin", carry_in, 1'b0);

    // 2: MUL to ACC+B
    alu(2'b10, 3'b101, 8'h01, 8'h08, 1'b0, 1'b0, 1'b1);
    step(); idle_in();
    chk("mul_acc", acc, 8'h01);
    chk("mul_b", b_reg, 8'h08);
    chk("mul_psw", psw, 8'h05);

    // 3: RAM write, ack in the third request cycle
    alu(2'b11, 3'b000, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);
    wb_addr = 8'h30;
    step(); idle_in();
    chk("ram_en_c1", ram_wr_en, 1'b1);
    chk("ram_addr", ram_wr_addr, 8'h30);
    chk("ram_data", ram_wr_data, 8'h5A);
    chk("ram_rdy_c1", wb_ready, 1'b0);
    alu(2'b01, 3'b111, 8'hAA, 8'h00, 1'b1, 1'b1, 1'b1);  // must be ignored
    step(); idle_in();
    chk("ram_en_c2", ram_wr_en, 1'b1);
    chk("ram_rdy_c2", wb_ready, 1'b0);
    chk("ram_acc_hold", acc, 8'h01);
    chk("ram_psw_hold", psw, 8'h05);
    step();
    chk("ram_en_c3", ram_wr_en, 1'b1);
    chk("ram_addr_c3", ram_wr_addr, 8'h30);
    chk("ram_data_c3", ram_wr_data, 8'h5A);
    ram_ack = 1'b1;
    step(); ram_ack = 1'b0;
    chk("ram_en_drop", ram_wr_en, 1'b0);
    chk("ram_rdy_back", wb_ready, 1'b1);

    // restore acc=60 (psw 05 -> P=0 -> 04)
    alu(2'b01, 3'b000, 8'h60, 8'h00, 1'b0, 1'b0, 1'b0);
    step(); idle_in();
    chk("acc60_psw", psw, 8'h04);

    // 4: PSW collision
    alu(2'b00, 3'b100, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    sfr_wr = 1'b1; sfr_addr = 8'hD0; sfr_data = 8'hFF;
    step(); idle_in();
    chk("psw_coll", psw, 8'h7E);
    chk("psw_coll_acc", acc, 8'h60);

    // 5: ACC collision
    alu(2'b01, 3'b000, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    sfr_wr = 1'b1; sfr_addr = 8'hE0; sfr_data = 8'h11;
    step(); idle_in();
    chk("acc_coll", acc, 8'h22);
    chk("acc_coll_p", psw[0], 1'b0);

    // flag feedback to the ALU
    alu(2'b00, 3'b100, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step(); idle_in();
    chk("cy_set_psw", psw, 8'hFE);
    chk("cy_cin", carry_in, 1'b1);
    alu(2'b00, 3'b010, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    step(); idle_in();
    chk("ac_clr_psw", psw, 8'hBE);
    chk("ac_aux_in", aux_carry_in, 1'b0);

    // plain SFR writes: B, an unmapped address, ACC
    sfr_wr = 1'b1; sfr_addr = 8'hF0; sfr_data = 8'h5C;
    step();
    sfr_addr = 8'h80; sfr_data = 8'h99;
    step();
    chk("sfr_b", b_reg, 8'h5C);
    chk("sfr_ign_acc", acc, 8'h22);
    sfr_addr = 8'hE0; sfr_data = 8'h07;
    step(); idle_in();
    chk("sfr_acc", acc, 8'h07);
    chk("sfr_acc_psw", psw, 8'hBF);

    // 6: reset while waiting on RAM
    alu(2'b11, 3'b000, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
    wb_addr = 8'h40;
    step(); idle_in();
    chk("r6_en", ram_wr_en, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r6_en_off", ram_wr_en, 1'b0);
    chk("r6_acc", acc, 8'h00);
    chk("r6_b", b_reg, 8'h00);
    chk("r6_psw", psw, 8'h00);
    chk("r6_ready", wb_ready, 1'b1);
    ram_ack = 1'b1;
    step(); ram_ack = 1'b0;
    chk("r6_late_ack_en", ram_wr_en, 1'b0);
    chk("r6_late_ack_rdy", wb_ready, 1'b1);
    chk("r6_late_ack_acc", acc, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
